dma_timing_ctrl: RTL and testbench

//  Bus-cycle timing/control FSM of the 8237A-style DMA. Sits downstream of dma_priority:
//  - consumes the any-channel request (valid_dreq) and the winning channel (grant_ch);
//  - produces hrq and valid_dack back to it;
//  - sequences states SI/S0/S1/S2/S3(+wait)/S4 and drives AEN, ADSTB, memory/IO strobes,
//    EOP, and address/count update pulses.

---
 rtl/dma_timing_ctrl.sv | 117 +++++++++++
 tb/tb_dma_timing_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dma_timing_ctrl.sv
// Bus-cycle timing FSM of an 8237A-style DMA: hold handshake, S0..S4 transfer
// sequencing with wait states, strobe decode, and termination handling.
module dma_timing_ctrl #(
  parameter int NUM_CH    = 4,
  parameter bit EXT_WRITE = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      valid_dreq,
  input  logic [$clog2(NUM_CH)-1:0] grant_ch,
  input  logic [1:0]                mode,
  input  logic [1:0]                xfer_type,
  input  logic                      hlda,
  input  logic                      ready,
  input  logic                      eop_n_in,
  input  logic                      tc,
  input  logic                      addr_hi_change,
  output logic                      hrq,
  output logic                      valid_dack,
  output logic [$clog2(NUM_CH)-1:0] active_ch,
  output logic                      aen,
  output logic                      adstb,
  output logic                      memr_n,
  output logic                      memw_n,
  output logic                      ior_n,
  output logic                      iow_n,
  output logic                      eop_n_out,
  output logic                      addr_update,
  output logic                      tc_set
);

  typedef enum logic [2:0] {
    ST_SI, ST_S0, ST_SC, ST_S1, ST_S2, ST_S3, ST_S4
  } state_t;

  localparam logic [1:0] MODE_DEMAND  = 2'b00;
  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_BLOCK   = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  state_t state, state_nxt;
  logic   eop_pend;
  logic   in_xfer;
  logic   terminate;
  logic   is_rd, is_wr;
  logic   rd_strb, wr_strb;

  assign in_xfer   = (state == ST_S1) || (state == ST_S2) ||
                     (state == ST_S3) || (state == ST_S4);
  // An EOP arriving in S4 itself must still end the service at this S4.
  assign terminate = tc || eop_pend || !eop_n_in;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SI: if (valid_dreq) state_nxt = ST_S0;
      ST_S0: begin
        if (hlda)            state_nxt = (mode == MODE_CASCADE) ? ST_SC : ST_S1;
        else if (!valid_dreq) state_nxt = ST_SI;
      end
      ST_SC: if (!hlda || !valid_dreq) state_nxt = ST_SI;
      ST_S1: state_nxt = hlda ? ST_S2 : ST_SI;
      ST_S2: state_nxt = hlda ? ST_S3 : ST_SI;
      ST_S3: begin
        if (!hlda)      state_nxt = ST_SI;
        else if (ready) state_nxt = ST_S4;
      end
      ST_S4: begin
        if (!hlda || terminate) state_nxt = ST_SI;
        else begin
          case (mode)
            MODE_BLOCK:  state_nxt = addr_hi_change ? ST_S1 : ST_S2;
            MODE_DEMAND: state_nxt = !valid_dreq ? ST_SI :
                                     (addr_hi_change ? ST_S1 : ST_S2);
            default:     state_nxt = ST_SI;
          endcase
        end
      end
      default: state_nxt = ST_SI;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_SI;
      active_ch <= '0;
      eop_pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_S0 && hlda) active_ch <= grant_ch;
      if (state_nxt == ST_SI)            eop_pend <= 1'b0;
      else if (in_xfer && !eop_n_in)     eop_pend <= 1'b1;
    end
  end

  // Strobe decode: read-side strobe opens in S2, write-side in S3 (or S2 when extended).
  assign is_rd   = (xfer_type == 2'b10);
  assign is_wr   = (xfer_type == 2'b01);
  assign rd_strb = (state == ST_S2) || (state == ST_S3);
  assign wr_strb = (state == ST_S3) || (EXT_WRITE && (state == ST_S2));

  always_comb begin
    hrq         = (state != ST_SI);
    valid_dack  = in_xfer || (state == ST_SC);
    aen         = in_xfer;
    adstb       = (state == ST_S1);
    memr_n      = !(is_rd && rd_strb);
    ior_n       = !(is_wr && rd_strb);
    iow_n       = !(is_rd && wr_strb);
    memw_n      = !(is_wr && wr_strb);
    // A hold-acknowledge drop in S4 aborts the transfer, so no count/TC side effects.
    addr_update = (state == ST_S4) && hlda;
    tc_set      = (state == ST_S4) && hlda && tc;
    eop_n_out   = !tc_set;
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Directed, table-driven bench for dma_timing_ctrl: one vector per clock, outputs
// compared just before the next rising edge against hand-computed values.
module tb_dma_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_dreq, hlda, ready, eop_n_in, tc, addr_hi_change;
  logic [1:0] grant_ch, mode, xfer_type;
  logic       hrq, valid_dack, aen, adstb, memr_n, memw_n, ior_n, iow_n;
  logic       eop_n_out, addr_update, tc_set;
  logic [1:0] active_ch;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [11:0] in;
    logic [12:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  dma_timing_ctrl #(.NUM_CH(4), .EXT_WRITE(1'b0)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .valid_dreq(valid_dreq), .grant_ch(grant_ch), .mode(mode), .xfer_type(xfer_type),
    .hlda(hlda), .ready(ready), .eop_n_in(eop_n_in), .tc(tc),
    .addr_hi_change(addr_hi_change),
    .hrq(hrq), .valid_dack(valid_dack), .active_ch(active_ch), .aen(aen), .adstb(adstb),
    .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n),
    .eop_n_out(eop_n_out), .addr_update(addr_update), .tc_set(tc_set)
  );

  // {dreq, grant_ch, mode, xfer_type, hlda, ready, eop_n_in, tc, addr_hi_change}
  function automatic logic [11:0] mk_in(int dreq, int gch, int md, int xt, int hl,
                                        int rdy, int eopn, int t, int ahc);
    return {1'(dreq), 2'(gch), 2'(md), 2'(xt), 1'(hl), 1'(rdy), 1'(eopn), 1'(t), 1'(ahc)};
  endfunction

  // {hrq, dack, active_ch, aen, adstb, memr_n, memw_n, ior_n, iow_n, eop_n_out, addr_update, tc_set}
  function automatic logic [12:0] mk_out(int h, int dk, int ch, int ae, int ad, int mr,
                                         int mw, int ir, int iw, int eo, int au, int ts);
    return {1'(h), 1'(dk), 2'(ch), 1'(ae), 1'(ad), 1'(mr), 1'(mw), 1'(ir), 1'(iw),
            1'(eo), 1'(au), 1'(ts)};
  endfunction

  function automatic logic [12:0] idle(int ch);
    return mk_out(0, 0, ch, 0, 0, 1, 1, 1, 1, 1, 0, 0);
  endfunction

  task automatic add(input logic [11:0] i, input logic [12:0] o, input string n);
    vec_t v;
    v.in = i; v.exp = o; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic check(input logic [12:0] exp, input string name);
    logic [12:0] act;
    act = {hrq, valid_dack, active_ch, aen, adstb, memr_n, memw_n, ior_n, iow_n,
           eop_n_out, addr_update, tc_set};
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input logic [11:0] in, input logic [12:0] exp, input string name);
    {valid_dreq, grant_ch, mode, xfer_type, hlda, ready, eop_n_in, tc, addr_hi_change} = in;
    #1;
    check(exp, name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {valid_dreq, grant_ch, mode, xfer_type, hlda, ready, eop_n_in, tc, addr_hi_change} =
      mk_in(0, 0, 0, 0, 0, 1, 1, 0, 0);

    // Single read, ch2
    add(mk_in(1,2,1,2,0,1,1,0,0), idle(0),                            "rd_si");
    add(mk_in(1,2,1,2,0,1,1,0,0), mk_out(1,0,0,0,0,1,1,1,1,1,0,0),    "rd_s0a");
    add(mk_in(1,2,1,2,0,1,1,0,0), mk_out(1,0,0,0,0,1,1,1,1,1,0,0),    "rd_s0b");
    add(mk_in(1,2,1,2,1,1,1,0,0), mk_out(1,0,0,0,0,1,1,1,1,1,0,0),    "rd_s0_hlda");
    add(mk_in(1,2,1,2,1,1,1,0,0), mk_out(1,1,2,1,1,1,1,1,1,1,0,0),    "rd_s1");
    add(mk_in(1,2,1,2,1,1,1,0,0), mk_out(1,1,2,1,0,0,1,1,1,1,0,0),    "rd_s2");
    add(mk_in(1,2,1,2,1,1,1,0,0), mk_out(1,1,2,1,0,0,1,1,0,1,0,0),    "rd_s3");
    add(mk_in(0,2,1,2,1,1,1,0,0), mk_out(1,1,2,1,0,1,1,1,1,1,1,0),    "rd_s4");
    add(mk_in(0,2,1,2,0,1,1,0,0), idle(2),                            "rd_si_end");
    // Single read, ch1, two wait states
    add(mk_in(1,1,1,2,0,1,1,0,0), idle(2),                            "wt_si");
    add(mk_in(1,1,1,2,1,1,1,0,0), mk_out(1,0,2,0,0,1,1,1,1,1,0,0),    "wt_s0");
    add(mk_in(1,1,1,2,1,1,1,0,0), mk_out(1,1,1,1,1,1,1,1,1,1,0,0),    "wt_s1");
    add(mk_in(1,1,1,2,1,0,1,0,0), mk_out(1,1,1,1,0,0,1,1,1,1,0,0),    "wt_s2");
    add(mk_in(1,1,1,2,1,0,1,0,0), mk_out(1,1,1,1,0,0,1,1,0,1,0,0),    "wt_s3w1");
    add(mk_in(1,1,1,2,1,0,1,0,0), mk_out(1,1,1,1,0,0,1,1,0,1,0,0),    "wt_s3w2");
    add(mk_in(1,1,1,2,1,1,1,0,0), mk_out(1,1,1,1,0,0,1,1,0,1,0,0),    "wt_s3rdy");
    add(mk_in(0,1,1,2,1,1,1,0,0), mk_out(1,1,1,1,0,1,1,1,1,1,1,0),    "wt_s4");
    add(mk_in(0,1,1,2,0,1,1,0,0), idle(1),                            "wt_si_end");
    // Block write, ch3, three transfers, tc on the third
    add(mk_in(1,3,2,1,0,1,1,0,0), idle(1),                            "blk_si");
    add(mk_in(1,3,2,1,1,1,1,0,0), mk_out(1,0,1,0,0,1,1,1,1,1,0,0),    "blk_s0");
    add(mk_in(1,3,2,1,1,1,1,0,0), mk_out(1,1,3,1,1,1,1,1,1,1,0,0),    "blk1_s1");
    add(mk_in(1,3,2,1,1,1,1,0,0), mk_out(1,1,3,1,0,1,1,0,1,1,0,0),    "blk1_s2");
    add(mk_in(1,3,2,1,1,1,1,0,0), mk_out(1,1,3,1,0,1,0,0,1,1,0,0),    "blk1_s3");
    add(mk_in(1,3,2,1,1,1,1,0,0), mk_out(1,1,3,1,0,1,1,1,1,1,1,0),    "blk1_s4");
    add(mk_in(1,3,2,1,1,1,1,0,1), mk_out(1,1,3,1,0,1,1,0,1,1,0,0),    "blk2_s2");
    add(mk_in(1,3,2,1,1,1,1,0,1), mk_out(1,1,3,1,0,1,0,0,1,1,0,0),    "blk2_s3");
    add(mk_in(1,3,2,1,1,1,1,0,1), mk_out(1,1,3,1,0,1,1,1,1,1,1,0),    "blk2_s4");
    add(mk_in(1,3,2,1,1,1,1,0,0), mk_out(1,1,3,1,1,1,1,1,1,1,0,0),    "blk3_s1");
    add(mk_in(1,3,2,1,1,1,1,0,0), mk_out(1,1,3,1,0,1,1,0,1,1,0,0),    "blk3_s2");
    add(mk_in(1,3,2,1,1,1,1,0,0), mk_out(1,1,3,1,0,1,0,0,1,1,0,0),    "blk3_s3");
    add(mk_in(0,3,2,1,1,1,1,1,0), mk_out(1,1,3,1,0,1,1,1,1,0,1,1),    "blk3_s4_tc");
    add(mk_in(0,3,2,1,0,1,1,0,0), idle(3),                            "blk_si_end");

    #2;
    check(idle(0), "reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i].in, tbl[i].exp, tbl[i].name);

    // Demand read, ch0: dreq falls during the second transfer
    apply(mk_in(1,0,0,2,0,1,1,0,0), idle(3),                          "dm_si");
    apply(mk_in(1,0,0,2,1,1,1,0,0), mk_out(1,0,3,0,0,1,1,1,1,1,0,0),  "dm_s0");
    apply(mk_in(1,0,0,2,1,1,1,0,0), mk_out(1,1,0,1,1,1,1,1,1,1,0,0),  "dm1_s1");
    apply(mk_in(1,0,0,2,1,1,1,0,0), mk_out(1,1,0,1,0,0,1,1,1,1,0,0),  "dm1_s2");
    apply(mk_in(1,0,0,2,1,1,1,0,0), mk_out(1,1,0,1,0,0,1,1,0,1,0,0),  "dm1_s3");
    apply(mk_in(1,0,0,2,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,1,0),  "dm1_s4");
    apply(mk_in(1,0,0,2,1,1,1,0,0), mk_out(1,1,0,1,0,0,1,1,1,1,0,0),  "dm2_s2");
    apply(mk_in(0,0,0,2,1,1,1,0,0), mk_out(1,1,0,1,0,0,1,1,0,1,0,0),  "dm2_s3");
    apply(mk_in(0,0,0,2,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,1,0),  "dm2_s4");
    // Demand verify: external EOP in S2 ends service after S4 despite dreq
    apply(mk_in(1,0,0,0,0,1,1,0,0), idle(0),                          "dm_si2");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,0,0,0,0,1,1,1,1,1,0,0),  "ev_s0");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,1,1,1,1,1,1,0,0),  "ev_s1");
    apply(mk_in(1,0,0,0,1,1,0,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,0,0),  "ev_s2_eop");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,0,0),  "ev_s3");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,1,0),  "ev_s4");
    apply(mk_in(1,0,0,0,0,1,1,0,0), idle(0),                          "ev_si");
    // Next demand service: pending EOP must not linger; then tc with EOP together
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,0,0,0,0,1,1,1,1,1,0,0),  "tc_s0");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,1,1,1,1,1,1,0,0),  "tc_s1");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,0,0),  "tc_s2");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,0,0),  "tc_s3");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,1,0),  "tc1_s4");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,0,0),  "tc2_s2");
    apply(mk_in(1,0,0,0,1,1,1,0,0), mk_out(1,1,0,1,0,1,1,1,1,1,0,0),  "tc2_s3");
    apply(mk_in(1,0,0,0,1,1,0,1,0), mk_out(1,1,0,1,0,1,1,1,1,0,1,1),  "tc2_s4_eop");
    apply(mk_in(0,0,0,0,0,1,1,0,0), idle(0),                          "tc_si");
    // Cascade, ch2
    apply(mk_in(1,2,3,2,0,1,1,0,0), idle(0),                          "cas_si");
    apply(mk_in(1,2,3,2,1,1,1,0,0), mk_out(1,0,0,0,0,1,1,1,1,1,0,0),  "cas_s0");
    apply(mk_in(1,2,3,2,1,1,1,0,0), mk_out(1,1,2,0,0,1,1,1,1,1,0,0),  "cas_sc1");
    apply(mk_in(0,2,3,2,1,1,1,0,0), mk_out(1,1,2,0,0,1,1,1,1,1,0,0),  "cas_sc2");
    apply(mk_in(0,2,3,2,0,1,1,0,0), idle(2),                          "cas_si_end");
    // hlda lost in S2 of a single write, ch1
    apply(mk_in(1,1,1,1,0,1,1,0,0), idle(2),                          "hd_si");
    apply(mk_in(1,1,1,1,1,1,1,0,0), mk_out(1,0,2,0,0,1,1,1,1,1,0,0),  "hd_s0");
    apply(mk_in(1,1,1,1,1,1,1,0,0), mk_out(1,1,1,1,1,1,1,1,1,1,0,0),  "hd_s1");
    apply(mk_in(1,1,1,1,0,1,1,0,0), mk_out(1,1,1,1,0,1,1,0,1,1,0,0),  "hd_s2_drop");
    apply(mk_in(0,1,1,1,0,1,1,0,0), idle(1),                          "hd_si_end");
    // Reset asserted while in a wait state of S3, ch2 write
    apply(mk_in(1,2,1,1,0,1,1,0,0), idle(1),                          "rs_si");
    apply(mk_in(1,2,1,1,1,1,1,0,0), mk_out(1,0,1,0,0,1,1,1,1,1,0,0),  "rs_s0");
    apply(mk_in(1,2,1,1,1,1,1,0,0), mk_out(1,1,2,1,1,1,1,1,1,1,0,0),  "rs_s1");
    apply(mk_in(1,2,1,1,1,0,1,0,0), mk_out(1,1,2,1,0,1,1,0,1,1,0,0),  "rs_s2");
    apply(mk_in(1,2,1,1,1,0,1,1,0), mk_out(1,1,2,1,0,1,0,0,1,1,0,0),  "rs_s3");
    rst_n = 1'b0;
    #1;
    check(idle(0), "rst_in_s3");
    {ready, tc} = 2'b11;
    @(posedge clk); #1;
    check(idle(0), "rst_held");
    rst_n = 1'b1;
    apply(mk_in(0,2,1,1,0,1,1,0,0), idle(0),                          "rs_si_after");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
